// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and helpers for the UART frame parser.
package uart_frame_pkg;

  localparam logic [7:0] ACK_BYTE         = 8'h06;
  localparam logic [7:0] NAK_BYTE         = 8'h15;
  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / packet-out / response-out bundle of the frame parser.
// master = the surrounding UART rx/tx and serial-out stage, slave = parser.
interface uart_frame_parser_if #(
  parameter int DATA_BIT = 8,
  parameter int PACK_NUM = 3
);
  logic [DATA_BIT-1:0]          i_data;
  logic                         i_rx_done_tick;
  logic [PACK_NUM*DATA_BIT-1:0] o_pack;
  logic                         o_pack_valid;
  logic                         i_pack_ready;
  logic                         o_tx_start;
  logic [DATA_BIT-1:0]          o_tx_data;
  logic [7:0]                   o_err_cnt;

  modport master (
    output i_data, i_rx_done_tick, i_pack_ready,
    input  o_pack, o_pack_valid, o_tx_start, o_tx_data, o_err_cnt
  );

  modport slave (
    input  i_data, i_rx_done_tick, i_pack_ready,
    output o_pack, o_pack_valid, o_tx_start, o_tx_data, o_err_cnt
  );
endinterface

// File: rtl/frame_timeout.sv
// Inter-byte idle watchdog. Counts while a frame is open, restarts on every
// received byte, and flags expiry for one cycle when the idle limit is hit.
module frame_timeout #(
  parameter int TIMEOUT_CYC = 20000,
  parameter int TO_BIT      = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expire
);

  logic [TO_BIT-1:0] cnt;

  // A byte arriving on the limit cycle wins over expiry.
  assign o_expire = i_run && !i_clear && (cnt == TO_BIT'(TIMEOUT_CYC - 1));

  // Idle counter: held at 0 outside a frame, restarted by bytes and by expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (!i_run || i_clear)       cnt <= '0;
    else if (o_expire)                cnt <= '0;
    else                              cnt <= cnt + TO_BIT'(1);
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SOF + payload + XOR checksum frames from UART rx bytes, hands
// verified payloads to the serial-out stage through a one-entry buffer and
// answers every frame outcome with an ACK/NAK byte on the UART tx.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int                  DATA_BIT    = 8,
  parameter int                  PACK_NUM    = 3,
  parameter logic [DATA_BIT-1:0] SOF_BYTE    = DATA_BIT'(SOF_BYTE_DEFAULT),
  parameter int                  TIMEOUT_CYC = 20000,
  parameter int                  TO_BIT      = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_frame_parser_if.slave   bus
);

  localparam int PW    = PACK_NUM * DATA_BIT;
  localparam int IDX_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [DATA_BIT-1:0] acc;
  logic [PW-1:0]       shreg;
  logic [PW-1:0]       pack_q;
  logic                pack_vld_q;
  logic                tx_start_q;
  logic [DATA_BIT-1:0] tx_data_q;
  logic [7:0]          err_q;

  logic tick, expire, consume, chk_ok, reject;

  assign tick    = bus.i_rx_done_tick;
  assign consume = pack_vld_q && bus.i_pack_ready;

  // Good checksum with room in the buffer (including a slot freed this cycle).
  assign chk_ok  = tick && (state == ST_CHECK) && (bus.i_data == acc) &&
                   (!pack_vld_q || bus.i_pack_ready);
  // Bad checksum, overflow, or inter-byte timeout all drop the frame.
  assign reject  = expire || (tick && (state == ST_CHECK) && !chk_ok);

  frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_BIT      (TO_BIT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (state != ST_IDLE),
    .i_clear  (tick),
    .o_expire (expire)
  );

  // Frame FSM with registered packet buffer and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      acc        <= '0;
      shreg      <= '0;
      pack_q     <= '0;
      pack_vld_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      if (consume) pack_vld_q <= 1'b0;

      if (reject) begin
        tx_start_q <= 1'b1;
        tx_data_q  <= DATA_BIT'(NAK_BYTE);
        err_q      <= sat_inc8(err_q);
        state      <= ST_IDLE;
      end else if (chk_ok) begin
        pack_q     <= shreg;
        pack_vld_q <= 1'b1;
        tx_start_q <= 1'b1;
        tx_data_q  <= DATA_BIT'(ACK_BYTE);
        state      <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            // Anything but SOF is line noise and is dropped silently.
            if (tick && bus.i_data == SOF_BYTE) begin
              acc   <= '0;
              idx   <= '0;
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            // SOF values here are plain data; there is no mid-frame resync.
            if (tick) begin
              shreg <= {shreg[PW-DATA_BIT-1:0], bus.i_data};
              acc   <= acc ^ bus.i_data;
              if (idx == IDX_W'(PACK_NUM - 1)) state <= ST_CHECK;
              else                             idx   <= idx + IDX_W'(1);
            end
          end
          ST_CHECK: ;  // resolved by chk_ok / reject above
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_pack       = pack_q;
  assign bus.o_pack_valid = pack_vld_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_err_cnt    = err_q;

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Upstream stage of `diff_freq_serial_out`. Assembles UART receive bytes into framed command packets: SOF byte, `PACK_NUM` payload bytes, XOR checksum. Each verified packet is presented to the serial-out stage through a one-entry valid/ready buffer. An ACK/NAK byte is returned to the UART transmitter for every frame outcome.

## Interface
- `DATA_BIT`, 8: UART byte width.
- `PACK_NUM`, 3: payload bytes per frame.
- `SOF_BYTE`, 8'hA5: start-of-frame marker.
- `TIMEOUT_CYC`, 20000: maximum idle clocks between bytes inside a frame (2 ms at 10 MHz).
- `TO_BIT`, 15: timeout counter width; must be ≥ log2(`TIMEOUT_CYC`).
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_data`  in  `DATA_BIT`  received UART byte; valid only while `i_rx_done_tick` is high.
- `i_rx_done_tick`  in  1  one-cycle strobe marking a received byte.
- `o_pack`  out  `PACK_NUM*DATA_BIT`  payload; first payload byte in the MSBs.
- `o_pack_valid`  out  1  buffer holds an unconsumed packet.
- `i_pack_ready`  in  1  downstream accepts `o_pack` when high together with `o_pack_valid`.
- `o_tx_start`  out  1  one-cycle strobe requesting transmission of `o_tx_data`.
- `o_tx_data`  out  `DATA_BIT`  response byte: 8'h06 ACK, 8'h15 NAK.
- `o_err_cnt`  out  8  saturating count of rejected frames.

## Operation
- FSM states: IDLE, PAYLOAD, CHECK.
- IDLE:
  - A byte equal to `SOF_BYTE` clears the checksum accumulator and the byte index, then moves to PAYLOAD.
  - Any other byte is discarded silently: no NAK, no count.
- PAYLOAD:
  - Each byte is shifted into the assembly register and XORed into the accumulator.
  - After byte `PACK_NUM-1` (index counts from 0), move to CHECK.
- CHECK, on the next byte:
  - Byte == accumulator and buffer free (or freed this cycle): load the buffer, send ACK, go to IDLE.
  - Byte ≠ accumulator: drop the frame, send NAK, increment `o_err_cnt`, go to IDLE.
  - Checksum good but buffer full and not being consumed this cycle (overflow): drop the frame, send NAK, increment `o_err_cnt`, go to IDLE.
- Timeout:
  - In PAYLOAD or CHECK, a counter increments every clock and clears on each `i_rx_done_tick`.
  - When the counter reaches `TIMEOUT_CYC-1`: send NAK, increment `o_err_cnt`, go to IDLE, clear the counter.
  - The counter is held at 0 in IDLE.
- A SOF value arriving inside a frame is treated as ordinary data. There is no resync mid-frame.
- `o_err_cnt` saturates at 8'hFF.

## Timing
- Reset values: FSM in IDLE; `o_pack` = 0; `o_pack_valid` = 0; `o_tx_start` = 0; `o_tx_data` = 0; `o_err_cnt` = 0; timeout counter, accumulator and byte index all 0.
- All outputs are registered.
- Latency: `o_pack_valid` and `o_tx_start` assert on the first clock edge after the cycle in which the checksum byte's `i_rx_done_tick` is sampled.
- A NAK caused by timeout asserts on the edge after the counter reaches `TIMEOUT_CYC-1`.
- `o_tx_start` is high for exactly one cycle. `o_tx_data` holds its value until the next response.
- Handshake:
  - `o_pack_valid` stays high and `o_pack` stays stable until the cycle where `i_pack_ready` is high; `o_pack_valid` falls on the following edge.
  - If a load and a consume happen in the same cycle, `o_pack_valid` stays high and `o_pack` takes the new payload.
- Rate assumption: response strobes are spaced at least one UART byte time apart, because each strobe is triggered by a received byte. No transmitter-busy input is needed.
- Reset mid-frame: all state is discarded immediately. `o_pack_valid` drops, with no NAK.

## Structure
- Shared package `uart_frame_pkg`:
  - constants `ACK_BYTE` = 8'h06, `NAK_BYTE` = 8'h15, default `SOF_BYTE`;
  - FSM state encoding (IDLE = 0, PAYLOAD = 1, CHECK = 2).
- One sub-module, `frame_timeout`:
  - parameters `TIMEOUT_CYC`, `TO_BIT`;
  - inputs `i_run`, `i_clear`;
  - output one-cycle `o_expire`.
- The top level instantiates this parser between the UART rx outputs and the `diff_freq_serial_out` inputs. The UART tx takes `o_tx_start` and `o_tx_data`.

## Test plan
- Good frame: bytes A5 12 34 56 70, `i_pack_ready` held low → `o_pack` = 24'h123456, `o_pack_valid` = 1, one `o_tx_start` with `o_tx_data` = 06, `o_err_cnt` = 0.
- Bad checksum: bytes A5 12 34 56 71 → no valid, `o_tx_data` = 15, `o_err_cnt` = 1.
- Overflow:
  - first good frame left unconsumed, then A5 01 02 03 00 → NAK, `o_pack` still 24'h123456, `o_err_cnt` increments;
  - repeat with `i_pack_ready` pulsed in the same cycle as the checksum byte → ACK, `o_pack` = 24'h010203.
- Timeout: bytes A5 12, then silence for 20000 clocks → NAK on the expiry edge, FSM in IDLE; a following good frame is accepted.
- Noise: bytes 00 FF 5A, then A5 AA BB CC DD → only one response (ACK), `o_pack` = 24'hAABBCC.
- Reset: assert `rst_n` low after A5 12 → all outputs 0; after release, A5 12 34 56 70 → ACK. Also drive 300 bad frames → `o_err_cnt` saturates at FF.
